// File: rtl/ram_arb_2p.sv
// ram_arb_2p: two-requester arbiter in front of a single-port synchronous
// read-first RAM. Commands are accepted one per cycle, registered onto the RAM
// port in the following cycle, and answered two cycles after acceptance.
// Optional build macro: RAM_ARB_FIXED_PRIO_EN (requester 0 always wins a tie;
// when undefined, ties are resolved round-robin with a last-grant pointer).
`timescale 1ns/1ps

module ram_arb_2p #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  logic                  accept;
  logic                  grantId;

  logic                  ramWe_q,   ramWe_d;
  logic [ADDR_WIDTH-1:0] ramAddr_q, ramAddr_d;
  logic [DATA_WIDTH-1:0] ramDin_q,  ramDin_d;

  logic                  s1Valid_q, s1Valid_d;
  logic                  s1Id_q,    s1Id_d;
  logic                  s2Valid_q;
  logic                  s2Id_q;

`ifdef RAM_ARB_FIXED_PRIO_EN
  // Pick the winner: a lone requester wins, requester 0 wins any tie.
  always_comb begin
    accept  = 1'b0;
    grantId = 1'b0;
    if (req0_valid) begin
      accept  = 1'b1;
      grantId = 1'b0;
    end else if (req1_valid) begin
      accept  = 1'b1;
      grantId = 1'b1;
    end
    if (!rst_n) begin
      accept = 1'b0;
    end
  end
`else
  logic lastGrant_q;

  // Pick the winner: a lone requester wins, a tie goes to whoever did not win last.
  always_comb begin
    accept  = 1'b0;
    grantId = 1'b0;
    if (req0_valid && req1_valid) begin
      accept  = 1'b1;
      grantId = ~lastGrant_q;
    end else if (req0_valid) begin
      accept  = 1'b1;
      grantId = 1'b0;
    end else if (req1_valid) begin
      accept  = 1'b1;
      grantId = 1'b1;
    end
    if (!rst_n) begin
      accept = 1'b0;
    end
  end

  // Remember the last winner; starts at requester 1 so requester 0 takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastGrant_q <= 1'b1;
    end else if (accept) begin
      lastGrant_q <= grantId;
    end
  end
`endif

  assign req0_ready = accept & ~grantId;
  assign req1_ready = accept &  grantId;

  // Next RAM command: the accepted command, or an idle cycle that keeps address/data.
  always_comb begin
    ramWe_d   = 1'b0;
    ramAddr_d = ramAddr_q;
    ramDin_d  = ramDin_q;
    s1Valid_d = accept;
    s1Id_d    = grantId;
    if (accept) begin
      ramWe_d   = grantId ? req1_we    : req0_we;
      ramAddr_d = grantId ? req1_addr  : req0_addr;
      ramDin_d  = grantId ? req1_wdata : req0_wdata;
    end
  end

  // Two-stage pipeline: stage 1 drives the RAM, stage 2 aligns with the RAM read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramWe_q   <= 1'b0;
      ramAddr_q <= '0;
      ramDin_q  <= '0;
      s1Valid_q <= 1'b0;
      s1Id_q    <= 1'b0;
      s2Valid_q <= 1'b0;
      s2Id_q    <= 1'b0;
    end else begin
      ramWe_q   <= ramWe_d;
      ramAddr_q <= ramAddr_d;
      ramDin_q  <= ramDin_d;
      s1Valid_q <= s1Valid_d;
      s1Id_q    <= s1Id_d;
      s2Valid_q <= s1Valid_q;
      s2Id_q    <= s1Id_q;
    end
  end

  assign ram_we     = ramWe_q;
  assign ram_addr   = ramAddr_q;
  assign ram_din    = ramDin_q;

  assign rsp0_valid = s2Valid_q & ~s2Id_q;
  assign rsp1_valid = s2Valid_q &  s2Id_q;
  assign rsp0_rdata = ram_dout;
  assign rsp1_rdata = ram_dout;

endmodule

// File: tb/tb_ram_arb_2p.sv
// tb_ram_arb_2p: directed and random checks of ram_arb_2p against a
// transaction-level model (grant rule, response queue, shadow memory).
`timescale 1ns/1ps

module tb_ram_arb_2p;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_we;
  logic [3:0] req0_addr;
  logic [7:0] req0_wdata;
  logic       req1_valid, req1_ready, req1_we;
  logic [3:0] req1_addr;
  logic [7:0] req1_wdata;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ramDout;

  ram_arb_2p #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ramDout)
  );

  always #5 clk = ~clk;

  // Power-on RAM contents, shared by the behavioural RAM and the shadow model.
  function automatic logic [7:0] initVal(input int a);
    return 8'(a * 29 + 7);
  endfunction

  // Behavioural single-port synchronous read-first RAM behind the arbiter.
  logic [7:0] ramMem [16];
  bit         ramWritten [16];
  always @(posedge clk) begin
    ramDout <= ramWritten[ram_addr] ? ramMem[ram_addr] : initVal(int'(ram_addr));
    if (ram_we) begin
      ramMem[ram_addr]     <= ram_din;
      ramWritten[ram_addr] <= 1'b1;
    end
  end

  typedef struct {
    int         due;
    bit         id;
    bit         we;
    logic [3:0] addr;
    logic [7:0] wdata;
  } PendEntry;

  PendEntry   pendQ[$];
  logic [7:0] shadow [16];
  int         lastWinner;
  int         cycleNo;
  bit         expRamWe;
  logic [3:0] expRamAddr;
  logic [7:0] expRamDin;
  int         total;
  int         bad;

  int         grantIds[$];
  int         grantCycles[$];
  int         rspIds[$];
  int         rspCycles[$];
  logic [7:0] rspData[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arbitration rule: lone requester wins; a tie follows the configured policy.
  function automatic int pickWinner(input bit v0, input bit v1);
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
    if (!v0 && !v1) return -1;
`ifdef RAM_ARB_FIXED_PRIO_EN
    return 0;
`else
    return (lastWinner == 0) ? 1 : 0;
`endif
  endfunction

  task automatic applyStimulus(input bit v0, input bit w0, input logic [3:0] a0, input logic [7:0] d0,
                               input bit v1, input bit w1, input logic [3:0] a1, input logic [7:0] d1);
    req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
  endtask

  // Compare one cycle of DUT outputs with the model, then advance the model.
  task automatic checkCycle();
    PendEntry   e;
    bit         exp0;
    bit         exp1;
    logic [7:0] expData;
    int         w;
    exp0 = 1'b0;
    exp1 = 1'b0;
    expData = '0;
    if (pendQ.size() > 0 && pendQ[0].due == cycleNo) begin
      e = pendQ.pop_front();
      expData = shadow[e.addr];
      if (e.we) shadow[e.addr] = e.wdata;
      if (e.id) exp1 = 1'b1; else exp0 = 1'b1;
    end
    checkOutput("rsp0_valid", 32'(rsp0_valid), 32'(exp0));
    checkOutput("rsp1_valid", 32'(rsp1_valid), 32'(exp1));
    if (exp0) checkOutput("rsp0_rdata", 32'(rsp0_rdata), 32'(expData));
    if (exp1) checkOutput("rsp1_rdata", 32'(rsp1_rdata), 32'(expData));
    checkOutput("ram_we", 32'(ram_we), 32'(expRamWe));
    checkOutput("ram_addr", 32'(ram_addr), 32'(expRamAddr));
    checkOutput("ram_din", 32'(ram_din), 32'(expRamDin));
    w = rst_n ? pickWinner(req0_valid, req1_valid) : -1;
    checkOutput("req0_ready", 32'(req0_ready), 32'(w == 0));
    checkOutput("req1_ready", 32'(req1_ready), 32'(w == 1));
    if (rsp0_valid) begin rspIds.push_back(0); rspCycles.push_back(cycleNo); rspData.push_back(rsp0_rdata); end
    if (rsp1_valid) begin rspIds.push_back(1); rspCycles.push_back(cycleNo); rspData.push_back(rsp1_rdata); end
    if (req0_ready) begin grantIds.push_back(0); grantCycles.push_back(cycleNo); end
    if (req1_ready) begin grantIds.push_back(1); grantCycles.push_back(cycleNo); end
    if (w >= 0) begin
      e.due   = cycleNo + 2;
      e.id    = (w == 1);
      e.we    = (w == 1) ? req1_we    : req0_we;
      e.addr  = (w == 1) ? req1_addr  : req0_addr;
      e.wdata = (w == 1) ? req1_wdata : req0_wdata;
      pendQ.push_back(e);
      lastWinner = w;
      expRamWe   = e.we;
      expRamAddr = e.addr;
      expRamDin  = e.wdata;
    end else begin
      expRamWe = 1'b0;
    end
    cycleNo++;
  endtask

  task automatic stepCycle(input bit v0, input bit w0, input logic [3:0] a0, input logic [7:0] d0,
                           input bit v1, input bit w1, input logic [3:0] a1, input logic [7:0] d1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(v0, w0, a0, d0, v1, w1, a1, d1);
    @(negedge clk);
    checkCycle();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
  endtask

  // Hold reset for two checked cycles with both requesters pushing; the next step releases it.
  task automatic resetDut();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    applyStimulus(1, 1, 4'h1, 8'hFF, 1, 1, 4'h2, 8'hEE);
    pendQ.delete();
    lastWinner = 1;
    expRamWe   = 1'b0;
    expRamAddr = '0;
    expRamDin  = '0;
    @(negedge clk);
    checkCycle();
    @(posedge clk);
    #1;
    @(negedge clk);
    checkCycle();
  endtask

  task automatic clearLogs();
    grantIds.delete(); grantCycles.delete();
    rspIds.delete(); rspCycles.delete(); rspData.delete();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int tieExp [4];
    total = 0;
    bad = 0;
    cycleNo = 0;
    lastWinner = 1;
    rst_n = 1'b0;
    applyStimulus(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
    for (int i = 0; i < 16; i++) shadow[i] = initVal(i);

    $display("[TB] reset state");
    resetDut();

    $display("[TB] write then read on requester 0");
    clearLogs();
    stepCycle(1, 1, 4'h3, 8'h55, 0, 0, 4'h0, 8'h00);
    stepCycle(1, 0, 4'h3, 8'h00, 0, 0, 4'h0, 8'h00);
    idleCycles(3);
    checkOutput("wr_rd_count", 32'(rspIds.size()), 32'd2);
    if (rspIds.size() == 2 && grantCycles.size() == 2) begin
      checkOutput("wr_rd_latency", 32'(rspCycles[0] - grantCycles[0]), 32'd2);
      checkOutput("wr_rd_data", 32'(rspData[1]), 32'h55);
    end

    $display("[TB] read-first write on requester 1");
    clearLogs();
    stepCycle(1, 1, 4'h5, 8'h11, 0, 0, 4'h0, 8'h00);
    stepCycle(0, 0, 4'h0, 8'h00, 1, 1, 4'h5, 8'hAA);
    stepCycle(0, 0, 4'h0, 8'h00, 1, 0, 4'h5, 8'h00);
    idleCycles(3);
    checkOutput("rdfirst_count", 32'(rspIds.size()), 32'd3);
    if (rspIds.size() == 3) begin
      checkOutput("rdfirst_old", 32'(rspData[1]), 32'h11);
      checkOutput("rdfirst_new", 32'(rspData[2]), 32'hAA);
      checkOutput("rdfirst_id", 32'(rspIds[1]), 32'd1);
    end

    $display("[TB] tie arbitration after reset");
    resetDut();
    clearLogs();
`ifdef RAM_ARB_FIXED_PRIO_EN
    tieExp = '{0, 0, 0, 0};
`else
    tieExp = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 4; i++) stepCycle(1, 0, 4'(i), 8'h00, 1, 0, 4'(i + 8), 8'h00);
    idleCycles(3);
    checkOutput("tie_grant_count", 32'(grantIds.size()), 32'd4);
    checkOutput("tie_rsp_count", 32'(rspIds.size()), 32'd4);
    if (grantIds.size() == 4 && rspIds.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput("tie_grant", 32'(grantIds[i]), 32'(tieExp[i]));
        checkOutput("tie_rsp_id", 32'(rspIds[i]), 32'(tieExp[i]));
        checkOutput("tie_rsp_latency", 32'(rspCycles[i] - grantCycles[i]), 32'd2);
      end
    end

    $display("[TB] reset while a read is in flight");
    clearLogs();
    stepCycle(1, 0, 4'h7, 8'h00, 0, 0, 4'h0, 8'h00);
    resetDut();
    idleCycles(4);
    checkOutput("midflight_rsp_count", 32'(rspIds.size()), 32'd0);

    $display("[TB] idle gap between two reads");
    clearLogs();
    stepCycle(0, 0, 4'h0, 8'h00, 1, 0, 4'h2, 8'h00);
    idleCycles(1);
    stepCycle(0, 0, 4'h0, 8'h00, 1, 0, 4'h4, 8'h00);
    idleCycles(3);
    checkOutput("gap_rsp_count", 32'(rspIds.size()), 32'd2);
    if (rspIds.size() == 2) begin
      checkOutput("gap_rsp_spacing", 32'(rspCycles[1] - rspCycles[0]), 32'd2);
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      stepCycle(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end
    idleCycles(3);
    checkOutput("random_drained", 32'(pendQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
